alsu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the single-stage ALSU: width-generic arithmetic/logic/shift unit with valid/ready flow control on input and output.
- Adds multi-bit shift/rotate by amount, error tagging per result, a saturating error counter and a clock-divided LED blink for invalid operations.
- Sits between the operand-select logic and the result bus / board LED driver.

---
 rtl/alsu_pipe.sv | 157 +++++++++++++++
 tb/tb_alsu_pipe.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage pipelined arithmetic/logic/shift unit
// with valid/ready flow control, error tagging and LED blink.
module alsu_pipe #(
    parameter int    BITS           = 8,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_DIV      = 4,
    parameter int    SH_W           = $clog2(BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   A,
    input  logic [BITS-1:0]   B,
    input  logic [2:0]        opcode,
    input  logic              cin,
    input  logic              SI,
    input  logic              sh_left,
    input  logic [SH_W-1:0]   shamt,
    input  logic              red_op_A,
    input  logic              red_op_B,
    output logic [2*BITS-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [15:0]       leds
);

    localparam int RW      = 2 * BITS;
    localparam bit PRI_B   = (INPUT_PRIORITY == "B");
    localparam bit USE_CIN = (FULL_ADDER == "ON");
    localparam int CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SHF = 3'b100;
    localparam logic [2:0] OP_ROT = 3'b101;

    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [2:0]      op;
        logic            cin;
        logic            si;
        logic            left;
        logic [SH_W-1:0] shamt;
        logic            ra;
        logic            rb;
    } s1_t;

    s1_t             s1;
    logic            s1_valid;
    logic            en;
    logic            delivered;
    logic [RW-1:0]   res;
    logic            inv;
    logic [BITS-1:0] red_sel;
    logic [BITS:0]   sum;
    logic            cin_eff;
    logic [BITS-1:0] fill;
    logic [SH_W-1:0] rot_amt;
    logic [BITS-1:0] shl_r;
    logic [BITS-1:0] shr_r;
    logic [BITS-1:0] rol_r;
    logic [BITS-1:0] ror_r;
    logic            blink;
    logic [CW-1:0]   bcnt;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign delivered = out_valid && out_ready;

    always_comb begin
        res     = '0;
        inv     = 1'b0;
        red_sel = (s1.ra && s1.rb) ? (PRI_B ? s1.b : s1.a)
                                   : (s1.ra ? s1.a : s1.b);
        cin_eff = USE_CIN ? s1.cin : 1'b0;
        sum     = {1'b0, s1.a} + {1'b0, s1.b} + {{BITS{1'b0}}, cin_eff};
        fill    = {BITS{s1.si}};
        rot_amt = SH_W'(int'(s1.shamt) % BITS);
        // Double-width windows let one shifter handle fill and wrap.
        shl_r   = BITS'(({s1.a, fill} << s1.shamt) >> BITS);
        shr_r   = BITS'({fill, s1.a} >> s1.shamt);
        rol_r   = BITS'(({s1.a, s1.a} << rot_amt) >> BITS);
        ror_r   = BITS'({s1.a, s1.a} >> rot_amt);
        unique case (s1.op)
            OP_AND: res = (s1.ra || s1.rb) ? RW'(&red_sel)
                                           : RW'(s1.a & s1.b);
            OP_XOR: res = (s1.ra || s1.rb) ? RW'(^red_sel)
                                           : RW'(s1.a ^ s1.b);
            OP_ADD: res = RW'(sum);
            OP_MUL: res = {{BITS{1'b0}}, s1.a} * {{BITS{1'b0}}, s1.b};
            OP_SHF: res = s1.left ? RW'(shl_r) : RW'(shr_r);
            OP_ROT: res = s1.left ? RW'(rol_r) : RW'(ror_r);
            default: inv = 1'b1;
        endcase
        if ((s1.ra || s1.rb) && s1.op != OP_AND && s1.op != OP_XOR) begin
            inv = 1'b1;
        end
        if (inv) begin
            res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= '{a: A, b: B, op: opcode, cin: cin, si: SI,
                        left: sh_left, shamt: shamt,
                        ra: red_op_A, rb: red_op_B};
            end
            out_valid <= s1_valid;
            out       <= s1_valid ? res : '0;
            err       <= s1_valid && inv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
            blink     <= 1'b0;
            bcnt      <= '0;
            leds      <= 16'h0000;
        end else if (delivered && err) begin
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            blink <= 1'b1;
            bcnt  <= '0;
            leds  <= 16'hFFFF;
        end else if (delivered) begin
            blink <= 1'b0;
            bcnt  <= '0;
            leds  <= 16'h0000;
        end else if (blink) begin
            if (bcnt == CW'(BLINK_DIV - 1)) begin
                bcnt <= '0;
                leds <= ~leds;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_alsu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  opcode;
    logic        cin;
    logic        SI;
    logic        sh_left;
    logic [2:0]  shamt;
    logic        red_op_A;
    logic        red_op_B;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [7:0]  err_count;
    logic [15:0] leds;

    int vectors = 0;
    int miscompares = 0;

    alsu_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .SI(SI),
        .sh_left(sh_left), .shamt(shamt), .red_op_A(red_op_A),
        .red_op_B(red_op_B), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .err_count(err_count),
        .leds(leds)
    );

    always #5 clk = ~clk;

    // Returns {err, out} computed straight from the operation rules.
    function automatic logic [16:0] model(
        input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
        input logic c, input logic si, input logic lft,
        input logic [2:0] sh, input logic ra, input logic rb);
        int av, bv, s, r, v;
        logic [7:0] pick;
        av = int'(a);
        bv = int'(b);
        s  = int'(sh);
        v  = 0;
        if (op >= 3'd6 || ((ra || rb) && op >= 3'd2)) return {1'b1, 16'h0};
        case (op)
            3'd0, 3'd1: begin
                if (ra || rb) begin
                    pick = ra ? a : b;
                    if (op == 3'd0) v = (pick == 8'hFF) ? 1 : 0;
                    else v = $countones(pick) % 2;
                end else begin
                    v = (op == 3'd0) ? (av & bv) : (av ^ bv);
                end
            end
            3'd2: v = av + bv + int'(c);
            3'd3: v = av * bv;
            3'd4: begin
                if (lft) v = ((av << s) & 255) | (si ? (1 << s) - 1 : 0);
                else v = (av >> s) | (si ? (255 & (255 << (8 - s))) : 0);
            end
            default: begin
                r = s % 8;
                if (lft) v = ((av << r) | (av >> (8 - r))) & 255;
                else v = ((av >> r) | (av << (8 - r))) & 255;
            end
        endcase
        return {1'b0, v[15:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        red_op_A = 1'b0;
        red_op_B = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic c,
                          input logic si, input logic lft,
                          input logic [2:0] sh,
                          input logic ra, input logic rb);
        A = a; B = b; opcode = op; cin = c; SI = si;
        sh_left = lft; shamt = sh; red_op_A = ra; red_op_B = rb;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        A = 0; B = 0; opcode = 0; cin = 0; SI = 0; sh_left = 0; shamt = 0;
        do_reset();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_out got %h want 0000", out);
        end
        vectors++;
        if (err !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_err got %b/%0d want 0/0", err, err_count);
        end
        vectors++;
        if (leds !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_leds got %h want 0000", leds);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_and_latency;
        do_reset();
        set_op(8'h0F, 8'h3C, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL and_early_valid got %b want 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out !== 16'h000C || err !== 1'b0) begin
            miscompares++;
            $display("FAIL and_result got v=%b out=%h err=%b want 1/000c/0",
                     out_valid, out, err);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        set_op(8'd255, 8'd1, 3'd2, 1, 0, 0, 3'd0, 0, 0);
        tick();
        set_op(8'd20, 8'd30, 3'd2, 1, 0, 0, 3'd0, 0, 0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out !== 16'd257) begin
            miscompares++;
            $display("FAIL add_carry got %0d v=%b want 257", out, out_valid);
        end
        set_op(8'd200, 8'd200, 3'd3, 0, 0, 0, 3'd0, 0, 0);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out !== 16'd51) begin
            miscompares++;
            $display("FAIL add_b2b got %0d v=%b want 51", out, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out !== 16'd40000) begin
            miscompares++;
            $display("FAIL mul got %0d v=%b want 40000", out, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_bubble got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_shift_rotate;
        do_reset();
        set_op(8'b1000_0001, 8'd0, 3'd4, 0, 1, 1, 3'd3, 0, 0);
        tick();
        set_op(8'h01, 8'd0, 3'd5, 0, 0, 0, 3'd1, 0, 0);
        tick();
        vectors++;
        if (out !== 16'h000F) begin
            miscompares++;
            $display("FAIL shift_left_si got %h want 000f", out);
        end
        set_op(8'h5A, 8'd0, 3'd4, 0, 1, 1, 3'd0, 0, 0);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out !== 16'h0080) begin
            miscompares++;
            $display("FAIL rotate_right got %h want 0080", out);
        end
        tick();
        vectors++;
        if (out !== 16'h005A || err !== 1'b0) begin
            miscompares++;
            $display("FAIL shift_zero got %h err=%b want 005a/0", out, err);
        end
    endtask

    task automatic test_reduce_err_leds;
        logic [15:0] want;
        do_reset();
        set_op(8'h07, 8'h01, 3'd1, 0, 0, 0, 3'd0, 1, 1);
        tick();
        set_op(8'h07, 8'h01, 3'd2, 0, 0, 0, 3'd0, 1, 1);
        tick();
        vectors++;
        if (out !== 16'h0001 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reduce_xor got %h err=%b want 0001/0", out, err);
        end
        in_valid = 1'b0;
        red_op_A = 1'b0;
        red_op_B = 1'b0;
        tick();
        vectors++;
        if (out !== 16'h0 || err !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reduce_add_err got %h err=%b want 0000/1", out, err);
        end
        tick();
        vectors++;
        if (err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL err_count_one got %0d want 1", err_count);
        end
        for (int k = 0; k < 12; k++) begin
            want = ((k / 4) % 2 == 0) ? 16'hFFFF : 16'h0000;
            vectors++;
            if (leds !== want) begin
                miscompares++;
                $display("FAIL blink_%0d got %h want %h", k, leds, want);
            end
            tick();
        end
        set_op(8'h0F, 8'h0F, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (leds !== 16'h0 || err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL blink_exit got %h cnt=%0d want 0000/1",
                     leds, err_count);
        end
        tick();
        vectors++;
        if (leds !== 16'h0) begin
            miscompares++;
            $display("FAIL blink_stay_off got %h want 0000", leds);
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int got;
        do_reset();
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = (cyc >= 5);
            if (idx < 4) begin
                set_op(8'(idx + 1), 8'(10 * (idx + 1)), 3'd2, 0, 0, 0,
                       3'd0, 0, 0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc < 5) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_ready_%0d got %b want 0",
                             cyc, in_ready);
                end
            end
            if (cyc == 4) begin
                vectors++;
                if (idx !== 2) begin
                    miscompares++;
                    $display("FAIL stall_accepts got %0d want 2", idx);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (got >= 4 || out !== 16'(11 * (got + 1))) begin
                    miscompares++;
                    $display("FAIL bp_order_%0d got %0d want %0d",
                             got, out, 11 * (got + 1));
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        vectors++;
        if (got !== 4 || idx !== 4) begin
            miscompares++;
            $display("FAIL bp_count got %0d/%0d want 4/4", got, idx);
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        set_op(8'h11, 8'h22, 3'd6, 0, 0, 0, 3'd0, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (err_count !== 8'd1 || leds !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL pre_reset got cnt=%0d leds=%h want 1/ffff",
                     err_count, leds);
        end
        set_op(8'd1, 8'd1, 3'd2, 0, 0, 0, 3'd0, 0, 0);
        tick();
        set_op(8'd2, 8'd2, 3'd2, 0, 0, 0, 3'd0, 0, 0);
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out !== 16'h0 ||
            err_count !== 8'd0 || leds !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset got v=%b out=%h cnt=%0d leds=%h",
                     out_valid, out, err_count, leds);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_result_%0d got v=%b out=%h want v=0",
                         k, out_valid, out);
            end
        end
    endtask

    task automatic test_saturate;
        do_reset();
        set_op(8'h00, 8'h00, 3'd7, 0, 0, 0, 3'd0, 0, 0);
        repeat (100) tick();
        vectors++;
        if (err_count !== 8'd98) begin
            miscompares++;
            $display("FAIL err_count_incr got %0d want 98", err_count);
        end
        repeat (170) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL err_count_sat got %0d want 255", err_count);
        end
    endtask

    task automatic test_random(input int n);
        logic [16:0] q[$];
        logic [16:0] exp;
        int          exp_cnt;
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < n + 20; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (i < n) begin
                set_op(8'($urandom), 8'($urandom), 3'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom),
                       3'($urandom),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            vectors++;
            if (in_ready !== (!out_valid || out_ready)) begin
                miscompares++;
                $display("FAIL rnd_in_ready_%0d got %b", i, in_ready);
            end
            vectors++;
            if (err_count !== 8'(exp_cnt)) begin
                miscompares++;
                $display("FAIL rnd_err_count_%0d got %0d want %0d",
                         i, err_count, exp_cnt);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_extra_%0d got out=%h want none", i, out);
                end else begin
                    exp = q.pop_front();
                    if ({err, out} !== exp) begin
                        miscompares++;
                        $display("FAIL rnd_result_%0d got %b/%h want %b/%h",
                                 i, err, out, exp[16], exp[15:0]);
                    end
                    if (exp[16] && exp_cnt < 255) exp_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, opcode, cin, SI, sh_left, shamt,
                                  red_op_A, red_op_B));
            end
            tick();
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_lost got %0d pending want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_and_latency();
        test_back_to_back();
        test_shift_rotate();
        test_reduce_err_leds();
        test_backpressure();
        test_reset_midstream();
        test_saturate();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
